// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants for the five-stage RV32I core: datapath and register-address
// widths, and the 4-bit ALU operation codes. The ALU control decoder and the
// ID/EX stage both use these codes, so they stay consistent.
// -----------------------------------------------------------------------------
package core_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   // ALU operation codes; any other code makes the ALU output zero.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Three-way priority operand select for one source register in EX:
// EX/MEM result first, then MEM/WB data, then the registered value.
// Register x0 never matches, whatever the rd and write-enable values.
// Ports:
//   rs, reg_data                          source register number and its value
//   exm_reg_write, exm_rd, exm_result     EX/MEM forwarding source
//   wb_reg_write, wb_rd, wb_data          MEM/WB forwarding source
//   fwd_data                              selected operand
// -----------------------------------------------------------------------------
module fwd_mux #(
   parameter int XLEN = core_pkg::XLEN,
   parameter int RAW  = core_pkg::RAW
) (
   input  logic [RAW-1:0]  rs,
   input  logic [XLEN-1:0] reg_data,
   input  logic            exm_reg_write,
   input  logic [RAW-1:0]  exm_rd,
   input  logic [XLEN-1:0] exm_result,
   input  logic            wb_reg_write,
   input  logic [RAW-1:0]  wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] fwd_data
);

   logic exm_hit_s;
   logic wb_hit_s;

   // Match detection with the x0 guard on both sources.
   always_comb begin
      exm_hit_s = exm_reg_write && (exm_rd != {RAW{1'b0}}) && (exm_rd == rs);
      wb_hit_s  = wb_reg_write  && (wb_rd  != {RAW{1'b0}}) && (wb_rd  == rs);
   end

   // Priority select: the younger EX/MEM result wins over MEM/WB.
   always_comb begin
      fwd_data = reg_data;
      if (exm_hit_s) begin
         fwd_data = exm_result;
      end else if (wb_hit_s) begin
         fwd_data = wb_data;
      end else begin
         fwd_data = reg_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register directly upstream of the ALU. Captures decoded
// operands and control from ID, bypasses same-cycle register-file writes at
// capture, forwards EX/MEM and MEM/WB results in the EX cycle, drives the ALU
// A/B/ALUCtrl inputs, stalls ID for one cycle on a load-use hazard and squashes
// its contents on a taken branch.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   id_valid / id_ready          ID handshake (id_ready combinational)
//   id_rs1, id_rs2, id_*_data    source registers and register-file data
//   id_imm, id_alu_src           immediate and B-operand select
//   id_alu_ctrl, id_rd, id_*     ALU code, destination, control bits
//   flush                        branch taken in EX, squash
//   exm_*, wb_*                  forwarding sources
//   A, B, ALUCtrl                ALU inputs
//   ex_*                         registered control, destination, store data
// -----------------------------------------------------------------------------
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN = core_pkg::XLEN,
   parameter int RAW  = core_pkg::RAW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [RAW-1:0]  id_rs1,
   input  logic [RAW-1:0]  id_rs2,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic [3:0]      id_alu_ctrl,
   input  logic [RAW-1:0]  id_rd,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_branch,
   input  logic            flush,
   input  logic [RAW-1:0]  exm_rd,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [RAW-1:0]  wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] A,
   output logic [XLEN-1:0] B,
   output logic [3:0]      ALUCtrl,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic [RAW-1:0]  ex_rd,
   output logic [XLEN-1:0] ex_store_data
);

   // Pipeline registers
   logic            ex_valid_r;
   logic [RAW-1:0]  ex_rs1_r;
   logic [RAW-1:0]  ex_rs2_r;
   logic [XLEN-1:0] ex_rs1_data_r;
   logic [XLEN-1:0] ex_rs2_data_r;
   logic [XLEN-1:0] ex_imm_r;
   logic            ex_alu_src_r;
   logic [3:0]      ex_alu_ctrl_r;
   logic [RAW-1:0]  ex_rd_r;
   logic            ex_reg_write_r;
   logic            ex_mem_read_r;
   logic            ex_mem_write_r;
   logic            ex_branch_r;

   // Combinational helpers
   logic            hazard_s;
   logic            bubble_s;
   logic [XLEN-1:0] cap_rs1_data_s;
   logic [XLEN-1:0] cap_rs2_data_s;
   logic [XLEN-1:0] fwd_rs1_s;
   logic [XLEN-1:0] fwd_rs2_s;

   // Load-use detection and the ID handshake; flush overrides the stall so
   // ID drops the squashed instruction instead of holding it.
   always_comb begin
      hazard_s = ex_valid_r && ex_mem_read_r && (ex_rd_r != {RAW{1'b0}}) &&
                 ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2)) && id_valid;
      bubble_s = flush || hazard_s;
      id_ready = flush || !hazard_s;
   end

   // Capture-time bypass: the register file is written and read in the same
   // cycle, so a matching WB write supplies the value ID could not yet see.
   always_comb begin
      cap_rs1_data_s = id_rs1_data;
      cap_rs2_data_s = id_rs2_data;
      if (wb_reg_write && (wb_rd != {RAW{1'b0}}) && (wb_rd == id_rs1)) begin
         cap_rs1_data_s = wb_data;
      end else begin
         cap_rs1_data_s = id_rs1_data;
      end
      if (wb_reg_write && (wb_rd != {RAW{1'b0}}) && (wb_rd == id_rs2)) begin
         cap_rs2_data_s = wb_data;
      end else begin
         cap_rs2_data_s = id_rs2_data;
      end
   end

   // ID/EX register: reset and bubbles clear everything, otherwise load ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_r     <= 1'b0;
         ex_rs1_r       <= {RAW{1'b0}};
         ex_rs2_r       <= {RAW{1'b0}};
         ex_rs1_data_r  <= {XLEN{1'b0}};
         ex_rs2_data_r  <= {XLEN{1'b0}};
         ex_imm_r       <= {XLEN{1'b0}};
         ex_alu_src_r   <= 1'b0;
         ex_alu_ctrl_r  <= ALU_AND;
         ex_rd_r        <= {RAW{1'b0}};
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
         ex_mem_write_r <= 1'b0;
         ex_branch_r    <= 1'b0;
      end else if (bubble_s) begin
         ex_valid_r     <= 1'b0;
         ex_rs1_r       <= {RAW{1'b0}};
         ex_rs2_r       <= {RAW{1'b0}};
         ex_rs1_data_r  <= {XLEN{1'b0}};
         ex_rs2_data_r  <= {XLEN{1'b0}};
         ex_imm_r       <= {XLEN{1'b0}};
         ex_alu_src_r   <= 1'b0;
         ex_alu_ctrl_r  <= ALU_AND;
         ex_rd_r        <= {RAW{1'b0}};
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
         ex_mem_write_r <= 1'b0;
         ex_branch_r    <= 1'b0;
      end else begin
         ex_valid_r     <= id_valid;
         ex_rs1_r       <= id_rs1;
         ex_rs2_r       <= id_rs2;
         ex_rs1_data_r  <= cap_rs1_data_s;
         ex_rs2_data_r  <= cap_rs2_data_s;
         ex_imm_r       <= id_imm;
         ex_alu_src_r   <= id_alu_src;
         ex_alu_ctrl_r  <= id_alu_ctrl;
         ex_rd_r        <= id_rd;
         ex_reg_write_r <= id_reg_write;
         ex_mem_read_r  <= id_mem_read;
         ex_mem_write_r <= id_mem_write;
         ex_branch_r    <= id_branch;
      end
   end

   fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
      .rs            (ex_rs1_r),
      .reg_data      (ex_rs1_data_r),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_result    (exm_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .fwd_data      (fwd_rs1_s)
   );

   fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
      .rs            (ex_rs2_r),
      .reg_data      (ex_rs2_data_r),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_result    (exm_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .fwd_data      (fwd_rs2_s)
   );

   // ALU operand drive; an invalid stage presents all-zero operands and code
   // so the ALU output is a harmless 0 (ex_branch is also 0 then).
   always_comb begin
      A             = {XLEN{1'b0}};
      B             = {XLEN{1'b0}};
      ex_store_data = {XLEN{1'b0}};
      ALUCtrl       = ALU_AND;
      if (ex_valid_r) begin
         A             = fwd_rs1_s;
         B             = ex_alu_src_r ? ex_imm_r : fwd_rs2_s;
         ex_store_data = fwd_rs2_s;
         ALUCtrl       = ex_alu_ctrl_r;
      end else begin
         A             = {XLEN{1'b0}};
         B             = {XLEN{1'b0}};
         ex_store_data = {XLEN{1'b0}};
         ALUCtrl       = ALU_AND;
      end
   end

   // Registered control straight out to EX/MEM.
   always_comb begin
      ex_valid     = ex_valid_r;
      ex_reg_write = ex_reg_write_r;
      ex_mem_read  = ex_mem_read_r;
      ex_mem_write = ex_mem_write_r;
      ex_branch    = ex_branch_r;
      ex_rd        = ex_rd_r;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic        id_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        id_alu_src;
   logic [3:0]  id_alu_ctrl;
   logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
   logic        flush;
   logic [4:0]  exm_rd, wb_rd;
   logic        exm_reg_write, wb_reg_write;
   logic [31:0] exm_result, wb_data;
   logic [31:0] A, B, ex_store_data;
   logic [3:0]  ALUCtrl;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
   logic [4:0]  ex_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RAW(5)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_branch(id_branch),
      .flush(flush),
      .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
      .A(A), .B(B), .ALUCtrl(ALUCtrl),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_rd(ex_rd), .ex_store_data(ex_store_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
      id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
      id_alu_src = 1'b0; id_alu_ctrl = 4'b0000;
      id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_branch = 1'b0;
      flush = 1'b0;
      exm_rd = 5'd0; exm_reg_write = 1'b0; exm_result = 32'd0;
      wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'd0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b want=0", ex_valid); end
      total++; if (A !== 32'd0) begin bad++; $display("FAIL reset_A got=%h want=0", A); end
      total++; if (B !== 32'd0) begin bad++; $display("FAIL reset_B got=%h want=0", B); end
      total++; if (ALUCtrl !== 4'b0000) begin bad++; $display("FAIL reset_ALUCtrl got=%b want=0000", ALUCtrl); end
      rst = 1'b0;
      #1;
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got=%b want=1", id_ready); end
   endtask

   task automatic test_capture();
      clear_inputs();
      id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_data = 32'd5; id_rs2 = 5'd2; id_rs2_data = 32'd3;
      id_alu_ctrl = 4'b0010; id_rd = 5'd5; id_reg_write = 1'b1;
      step();
      id_valid = 1'b0;
      #1;
      total++; if (A !== 32'd5) begin bad++; $display("FAIL capture_A got=%h want=5", A); end
      total++; if (B !== 32'd3) begin bad++; $display("FAIL capture_B got=%h want=3", B); end
      total++; if (ALUCtrl !== 4'b0010) begin bad++; $display("FAIL capture_ALUCtrl got=%b want=0010", ALUCtrl); end
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL capture_ex_valid got=%b want=1", ex_valid); end
      total++; if (ex_rd !== 5'd5) begin bad++; $display("FAIL capture_ex_rd got=%0d want=5", ex_rd); end
      total++; if (ex_reg_write !== 1'b1) begin bad++; $display("FAIL capture_ex_reg_write got=%b want=1", ex_reg_write); end
      total++; if (ex_store_data !== 32'd3) begin bad++; $display("FAIL capture_store got=%h want=3", ex_store_data); end
   endtask

   // Relies on the instruction left in EX by test_capture (rs1=x1=5, rs2=x2=3).
   task automatic test_ex_forward();
      exm_reg_write = 1'b1; exm_rd = 5'd1; exm_result = 32'h10;
      wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h20;
      #1;
      total++; if (A !== 32'h10) begin bad++; $display("FAIL fwd_exm_wins got=%h want=10", A); end
      exm_rd = 5'd0;
      #1;
      total++; if (A !== 32'h20) begin bad++; $display("FAIL fwd_wb_when_exm_x0 got=%h want=20", A); end
      wb_rd = 5'd0;
      #1;
      total++; if (A !== 32'd5) begin bad++; $display("FAIL fwd_none_x0 got=%h want=5", A); end
      wb_rd = 5'd2; wb_data = 32'h44;
      #1;
      total++; if (B !== 32'h44) begin bad++; $display("FAIL fwd_wb_rs2_B got=%h want=44", B); end
      total++; if (ex_store_data !== 32'h44) begin bad++; $display("FAIL fwd_wb_rs2_store got=%h want=44", ex_store_data); end
      exm_reg_write = 1'b0; exm_rd = 5'd2; exm_result = 32'h77;
      #1;
      total++; if (B !== 32'h44) begin bad++; $display("FAIL fwd_exm_disabled got=%h want=44", B); end
      clear_inputs();
   endtask

   task automatic test_load_use();
      clear_inputs();
      id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd3; id_reg_write = 1'b1; id_alu_ctrl = 4'b0010;
      step();
      total++; if (ex_mem_read !== 1'b1) begin bad++; $display("FAIL lu_load_in_ex got=%b want=1", ex_mem_read); end
      clear_inputs();
      id_valid = 1'b1; id_rs1 = 5'd6; id_rs1_data = 32'd9; id_rs2 = 5'd3; id_rs2_data = 32'd11;
      id_alu_ctrl = 4'b0001; id_rd = 5'd7; id_reg_write = 1'b1;
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b want=0", id_ready); end
      step();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%b want=0", ex_valid); end
      total++; if (A !== 32'd0 || B !== 32'd0) begin bad++; $display("FAIL lu_bubble_AB got=%h/%h want=0/0", A, B); end
      total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL lu_bubble_ctrl got=%b want=0", ex_reg_write); end
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_one_cycle got=%b want=1", id_ready); end
      step();
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_capture_valid got=%b want=1", ex_valid); end
      total++; if (A !== 32'd9 || B !== 32'd11) begin bad++; $display("FAIL lu_capture_AB got=%h/%h want=9/b", A, B); end
      total++; if (ALUCtrl !== 4'b0001) begin bad++; $display("FAIL lu_capture_ctrl got=%b want=0001", ALUCtrl); end
      clear_inputs();
      step();
   endtask

   task automatic test_flush_hazard();
      clear_inputs();
      id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd3; id_reg_write = 1'b1;
      step();
      clear_inputs();
      id_valid = 1'b1; id_rs2 = 5'd3; id_rs2_data = 32'd1; id_branch = 1'b1; id_alu_ctrl = 4'b0110;
      flush = 1'b1;
      #1;
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_id_ready got=%b want=1", id_ready); end
      step();
      flush = 1'b0; id_valid = 1'b0;
      #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_bubble_valid got=%b want=0", ex_valid); end
      total++; if (ex_branch !== 1'b0) begin bad++; $display("FAIL flush_branch got=%b want=0", ex_branch); end
      total++; if (ALUCtrl !== 4'b0000) begin bad++; $display("FAIL flush_ALUCtrl got=%b want=0000", ALUCtrl); end
      clear_inputs();
   endtask

   task automatic test_wb_bypass();
      clear_inputs();
      id_valid = 1'b1; id_rs1 = 5'd4; id_rs1_data = 32'd0; id_alu_ctrl = 4'b0010;
      wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'd7;
      step();
      clear_inputs();
      #1;
      total++; if (A !== 32'd7) begin bad++; $display("FAIL bypass_wb_A got=%h want=7", A); end
      id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_data = 32'h55; id_alu_ctrl = 4'b0010;
      wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'd7;
      step();
      id_valid = 1'b0;
      exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'h99;
      #1;
      total++; if (A !== 32'h55) begin bad++; $display("FAIL bypass_x0_A got=%h want=55", A); end
      clear_inputs();
   endtask

   task automatic test_imm();
      clear_inputs();
      id_valid = 1'b1; id_alu_src = 1'b1; id_imm = 32'hFFFFFFFC; id_alu_ctrl = 4'b0110;
      id_rs1 = 5'd8; id_rs1_data = 32'd20; id_rs2 = 5'd2; id_rs2_data = 32'd3;
      step();
      id_valid = 1'b0;
      #1;
      total++; if (B !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_B got=%h want=fffffffc", B); end
      total++; if (ex_store_data !== 32'd3) begin bad++; $display("FAIL imm_store got=%h want=3", ex_store_data); end
      total++; if (ALUCtrl !== 4'b0110) begin bad++; $display("FAIL imm_ALUCtrl got=%b want=0110", ALUCtrl); end
      exm_reg_write = 1'b1; exm_rd = 5'd2; exm_result = 32'h123;
      #1;
      total++; if (B !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_B_fwd got=%h want=fffffffc", B); end
      total++; if (ex_store_data !== 32'h123) begin bad++; $display("FAIL imm_store_fwd got=%h want=123", ex_store_data); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_data = 32'd9; id_alu_ctrl = 4'b0010; id_reg_write = 1'b1;
      step();
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", ex_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", ex_valid); end
      total++; if (A !== 32'd0) begin bad++; $display("FAIL mid_async_A got=%h want=0", A); end
      total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL mid_async_ctrl got=%b want=0", ex_reg_write); end
      step();
      rst = 1'b0;
      clear_inputs();
      step();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_capture();
      test_ex_forward();
      test_load_use();
      test_flush_hazard();
      test_wb_bypass();
      test_imm();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
